// File: rtl/calc_feeder_pkg.sv
// Shared widths, state encoding and a small arithmetic helper for the
// calc_feeder front-end sequencer.
package calc_feeder_pkg;

   localparam int PIX_W     = 3;
   localparam int FSUM_W    = 11;
   localparam int F2SUM_W   = 14;
   localparam int PLACE_W   = 6;
   localparam int PIX_CNT_W = 8;
   localparam int CAND_W    = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PAIR  = 3'd2,
      ST_GAP   = 3'd3,
      ST_FINAL = 3'd4
   } state_t;

   function automatic logic [2*PIX_W-1:0] pix_sq(input logic [PIX_W-1:0] p);
      return {{PIX_W{1'b0}}, p} * {{PIX_W{1'b0}}, p};
   endfunction

endpackage

// File: rtl/calc_feeder_win_store.sv
// Single-port WIN x 3 window store: written while loading the reference
// window, read once per replayed pixel. Read data is registered and holds.
module calc_feeder_win_store
   import calc_feeder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [AW-1:0]    i_addr,
   input  logic [PIX_W-1:0] i_wdata,
   output logic [PIX_W-1:0] o_rdata
);

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   // Only the output register is reset so fdata reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/calc_feeder.sv
// Captures one reference window, then replays it once per candidate while
// pairing it with the candidate stream and generating correlation strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; sums and startplace hold last run
// ST_LOAD  | f_ready=1, store f window, accumulate sum and sum of squares
// ST_PAIR  | g_ready=1, each accepted g is paired with the stored f[pix]
// ST_GAP   | one cycle between candidates, advance cand, rewind pix
// ST_FINAL | one cycle, last candidate finished
module calc_feeder
   import calc_feeder_pkg::*;
#(
   parameter int WIN   = 256,
   parameter int NCAND = 64
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [PLACE_W-1:0] start_place_in,
   input  logic [PIX_W-1:0]   f_in,
   input  logic               f_valid,
   output logic               f_ready,
   input  logic [PIX_W-1:0]   g_in,
   input  logic               g_valid,
   output logic               g_ready,
   output logic               startsig,
   output logic               work,
   output logic               valid,
   output logic               change,
   output logic               finalstart,
   output logic [PIX_W-1:0]   fdata,
   output logic [PIX_W-1:0]   gdata,
   output logic [FSUM_W-1:0]  fsum,
   output logic [F2SUM_W-1:0] f2sum,
   output logic [PLACE_W-1:0] startplace,
   output logic               busy,
   output logic               done
);

   localparam int AW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [PIX_CNT_W-1:0] PIX_LAST  = PIX_CNT_W'(WIN - 1);
   localparam logic [CAND_W-1:0]    CAND_LAST = CAND_W'(NCAND - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PIX_CNT_W-1:0] r_pix;
   logic [CAND_W-1:0]    r_cand;
   logic [FSUM_W-1:0]    r_fsum;
   logic [F2SUM_W-1:0]   r_f2sum;
   logic [PLACE_W-1:0]   r_place;
   logic [PIX_W-1:0]     r_gdata;
   logic                 r_valid;
   logic                 r_startsig;
   logic                 r_change;
   logic                 r_final;
   logic                 w_start_acc;
   logic                 w_f_acc;
   logic                 w_g_acc;
   logic                 w_pix_last;
   logic                 w_cand_last;
   logic [PIX_W-1:0]     w_fdata;

   assign w_f_acc     = f_ready & f_valid;
   assign w_g_acc     = g_ready & g_valid;
   assign w_pix_last  = (r_pix == PIX_LAST);
   assign w_cand_last = (r_cand == CAND_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      f_ready     = 1'b0;
      g_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            f_ready = 1'b1;
            if (f_valid && w_pix_last) w_state_nxt = ST_PAIR;
         end
         ST_PAIR: begin
            g_ready = 1'b1;
            if (g_valid && w_pix_last) w_state_nxt = w_cand_last ? ST_FINAL : ST_GAP;
         end
         ST_GAP:   w_state_nxt = ST_PAIR;
         ST_FINAL: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are registered one cycle after their state so that the last
   // pair's valid and the following change/finalstart land on consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix      <= '0;
         r_cand     <= '0;
         r_fsum     <= '0;
         r_f2sum    <= '0;
         r_place    <= '0;
         r_gdata    <= '0;
         r_valid    <= 1'b0;
         r_startsig <= 1'b0;
         r_change   <= 1'b0;
         r_final    <= 1'b0;
      end else begin
         r_valid    <= w_g_acc;
         r_startsig <= w_g_acc && (r_cand == '0) && (r_pix == '0);
         r_change   <= (r_state == ST_GAP);
         r_final    <= (r_state == ST_FINAL);
         if (w_g_acc) r_gdata <= g_in;
         if (w_start_acc) begin
            r_fsum  <= '0;
            r_f2sum <= '0;
            r_pix   <= '0;
            r_cand  <= '0;
            r_place <= start_place_in;
         end
         if (w_f_acc) begin
            r_fsum  <= r_fsum + FSUM_W'(f_in);
            r_f2sum <= r_f2sum + F2SUM_W'(pix_sq(f_in));
         end
         if (w_f_acc || w_g_acc) r_pix <= w_pix_last ? '0 : r_pix + PIX_CNT_W'(1);
         if (r_state == ST_GAP) begin
            r_cand <= r_cand + CAND_W'(1);
            r_pix  <= '0;
         end
      end
   end

   calc_feeder_win_store #(
      .DEPTH (WIN),
      .AW    (AW)
   ) u_win_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_f_acc),
      .i_re    (w_g_acc),
      .i_addr  (r_pix[AW-1:0]),
      .i_wdata (f_in),
      .o_rdata (w_fdata)
   );

   assign startsig   = r_startsig;
   assign valid      = r_valid;
   assign change     = r_change;
   assign finalstart = r_final;
   assign done       = r_final;
   assign fdata      = w_fdata;
   assign gdata      = r_gdata;
   assign fsum       = r_fsum;
   assign f2sum      = r_f2sum;
   assign startplace = r_place;
   assign busy       = (r_state != ST_IDLE);
   // Held through the registered finalstart so the unit sees it inside work.
   assign work       = (r_state == ST_PAIR) || (r_state == ST_GAP) ||
                       (r_state == ST_FINAL) || r_final;

endmodule

// File: tb/tb_calc_feeder.sv
// Directed bench for calc_feeder: full-rate, ramp, stalled and aborted runs.
module tb_calc_feeder;

   localparam int WIN    = 256;
   localparam int NCAND  = 12;
   localparam int NPAIR  = WIN * NCAND;
   localparam int RUNLEN = 1 + WIN + NPAIR + (NCAND - 1) + 1;
   localparam int BUDGET = 12000;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] start_place_in;
   logic [2:0] f_in;
   logic       f_valid;
   logic       f_ready;
   logic [2:0] g_in;
   logic       g_valid;
   logic       g_ready;
   logic       startsig, work, valid, change, finalstart;
   logic [2:0] fdata, gdata;
   logic [10:0] fsum;
   logic [13:0] f2sum;
   logic [5:0] startplace;
   logic       busy, done;

   calc_feeder #(.WIN(WIN), .NCAND(NCAND)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_place_in (start_place_in),
      .f_in           (f_in),
      .f_valid        (f_valid),
      .f_ready        (f_ready),
      .g_in           (g_in),
      .g_valid        (g_valid),
      .g_ready        (g_ready),
      .startsig       (startsig),
      .work           (work),
      .valid          (valid),
      .change         (change),
      .finalstart     (finalstart),
      .fdata          (fdata),
      .gdata          (gdata),
      .fsum           (fsum),
      .f2sum          (f2sum),
      .startplace     (startplace),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] w_outs;
   assign w_outs = {18'd0, startsig, work, valid, change, finalstart, fdata, gdata,
                    fsum, f2sum, startplace, busy, done, f_ready, g_ready};

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] fexp [WIN];
   logic [2:0] gseq [NPAIR];
   int m_fsum, m_f2sum;
   int n_fready, n_valid, n_ss, n_chg, n_fin, n_done;
   int e_f, e_g, e_al;
   int done_cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic run(input string nm, input int fmode, input bit g_rand, input bit stall,
                      input bit inj_start, input bit do_rst, input logic [5:0] place);
      int  n, fi, gi, vg, vpix;
      bit  f_acc, g_acc, prev_v, stop;
      m_fsum = 0; m_f2sum = 0;
      for (int i = 0; i < WIN; i++) begin
         case (fmode)
            0:       fexp[i] = 3'd7;
            1:       fexp[i] = 3'(i % 8);
            default: fexp[i] = 3'($urandom_range(7));
         endcase
         m_fsum  += int'(fexp[i]);
         m_f2sum += int'(fexp[i]) * int'(fexp[i]);
      end
      for (int k = 0; k < NPAIR; k++) gseq[k] = g_rand ? 3'($urandom_range(7)) : 3'd7;
      n_fready = 0; n_valid = 0; n_ss = 0; n_chg = 0; n_fin = 0; n_done = 0;
      e_f = 0; e_g = 0; e_al = 0; done_cyc = -1;
      n = 0; fi = 0; gi = 0; vg = 0; vpix = 0; prev_v = 0; stop = 0;
      start = 1'b1; start_place_in = place;
      f_in = fexp[0]; f_valid = 1'b1;
      g_in = gseq[0]; g_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!stop) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({nm, "_load_next"}, {busy, f_ready, startplace}, {2'b11, place});
         if (f_ready) n_fready++;
         if (valid) begin
            n_valid++;
            if (fdata !== fexp[vpix]) e_f++;
            if (vg < NPAIR && gdata !== gseq[vg]) e_g++;
            vg++;
            vpix = (vpix + 1) % WIN;
            if (!work) e_al++;
         end
         if (startsig) begin
            n_ss++;
            if (!valid || n_valid != 1) e_al++;
         end
         if (change) begin
            n_chg++;
            if (valid || !prev_v || vpix != 0) e_al++;
         end
         if (finalstart) begin
            n_fin++;
            if (valid || !prev_v || vpix != 0 || n_valid != NPAIR || !work) e_al++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = n;
         end
         prev_v = valid;
         if (done_cyc >= 0 && n >= done_cyc + 3) stop = 1;
         if (n >= BUDGET) stop = 1;
         if (do_rst && !stop && n_chg == 10 && vpix == 100) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_async_outs", w_outs, 64'd0);
            chk("rst_no_done", n_done, 0);
            start = 1'b0; f_valid = 1'b0; g_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk("rst_held_outs", w_outs, 64'd0);
            rst_n = 1'b1;
            stop = 1;
         end
         f_acc = f_valid && f_ready;
         g_acc = g_valid && g_ready;
         if (inj_start && n == 400) begin
            start = 1'b1;
            start_place_in = 6'd5;
         end
         if (!stop) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (f_acc) begin
               fi++;
               if (fi < WIN) f_in = fexp[fi];
               else          f_in = 3'd0;
            end
            if (g_acc) begin
               gi++;
               if (gi < NPAIR) g_in = gseq[gi];
            end
            g_valid = stall ? 1'($urandom_range(1)) : 1'b1;
         end
      end
      f_valid = 1'b0;
      g_valid = 1'b0;
      if (!do_rst) chk({nm, "_done_seen"}, done_cyc >= 0, 1);
   endtask

   task automatic post(input string nm, input bit full_rate, input logic [5:0] place);
      if (full_rate) chk({nm, "_done_cycle"}, done_cyc, RUNLEN);
      chk({nm, "_done_pulses"}, n_done, 1);
      chk({nm, "_finalstart"}, n_fin, 1);
      chk({nm, "_startsig"}, n_ss, 1);
      chk({nm, "_change"}, n_chg, NCAND - 1);
      chk({nm, "_valid_cnt"}, n_valid, NPAIR);
      chk({nm, "_load_cycles"}, n_fready, WIN);
      chk({nm, "_fdata_err"}, e_f, 0);
      chk({nm, "_gdata_err"}, e_g, 0);
      chk({nm, "_strobe_err"}, e_al, 0);
      chk({nm, "_fsum"}, fsum, m_fsum);
      chk({nm, "_f2sum"}, f2sum, m_f2sum);
      chk({nm, "_startplace"}, startplace, place);
      chk({nm, "_idle"}, {busy, work, f_ready, g_ready}, 4'b0000);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_place_in = '0;
      f_in = '0; f_valid = 1'b0; g_in = '0; g_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", w_outs, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("A", 0, 0, 0, 0, 0, 6'd37);
      post("A", 1, 6'd37);
      chk("A_fsum_max", fsum, 1792);
      chk("A_f2sum_max", f2sum, 12544);

      run("B", 1, 1, 0, 0, 0, 6'd12);
      post("B", 1, 6'd12);
      chk("B_fsum_ramp", fsum, 896);
      chk("B_f2sum_ramp", f2sum, 4480);

      run("C", 2, 1, 1, 1, 0, 6'd37);
      post("C", 0, 6'd37);

      run("D", 0, 0, 0, 0, 1, 6'd9);

      run("E", 1, 1, 0, 0, 0, 6'd63);
      post("E", 1, 6'd63);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
